fifo_drain_ctrl: RTL and testbench
==================================

# fifo_drain_ctrl

This block sequences the read side of the 8-bit sample FIFO and streams its bytes to the byte-serial transmitter over a valid/ready handshake. It generates the FIFO's edge-sensitive read_en pulse and respects the FIFO's one-cycle lag between empty deasserting and d_out becoming valid. It can optionally insert a sync byte ahead of every fixed-length frame. It sits between the FIFO output and the UART TX.

## Interface
- FRAME_LEN, 0: data bytes per frame; 0 disables sync insertion.
- SYNC_BYTE, 8'hA5: header byte emitted at the start of each frame.
- SETTLE_CYCLES, 1: wait cycles between seeing not-empty and sampling fifo_dout; legal range 1–15.
- sys_clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  permits starting a new byte or frame.
- fifo_empty  in  1  FIFO isEmpty.
- fifo_dout  in  8  FIFO d_out.
- fifo_read_en  out  1  FIFO read_en. The FIFO advances on the falling edge of this signal.
- tx_data  out  8  byte offered to the TX.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  TX accepts the byte when tx_valid and tx_ready are both high at a rising edge.
- busy  out  1  high when state != IDLE or tx_valid is high.
- byte_count  out  16  FIFO bytes handed to TX since reset; sync bytes excluded; wraps.

## Operation
- Reset values: fifo_read_en=0, tx_valid=0, tx_data=0, busy=0, byte_count=0. State=IDLE, frame_cnt=0, settle counter=0.
- IDLE: if enable is high and fifo_empty is low:
  - go to SYNC if FRAME_LEN≠0 and frame_cnt=0;
  - otherwise go to WAIT.
- SYNC: on entry, tx_data=SYNC_BYTE and tx_valid=1 (entered only when tx_valid=0). Hold until the handshake completes, then go to WAIT.
- WAIT: count SETTLE_CYCLES cycles, then go to LOAD.
- LOAD: if tx_valid=0 (registered value), capture tx_data←fifo_dout, set tx_valid=1, increment byte_count, go to POP_HI. Otherwise stall in LOAD.
  - frame_cnt increments on capture and wraps to 0 after FRAME_LEN−1.
- POP_HI: fifo_read_en=1 for exactly this cycle; go to POP_LO.
- POP_LO: fifo_read_en=0 (falling edge, so the FIFO pointer advances); go to SETTLE.
- SETTLE: one cycle for the pointer and empty flag to update; go to IDLE.
- tx_valid clears on the handshake edge. tx_data is stable while tx_valid=1.
- The byte pop (POP_HI..SETTLE) overlaps with TX backpressure, because the data is already captured.
- enable low: the current sequence runs to IDLE, and the pending tx byte still completes. No new pop or sync byte starts.
- fifo_read_en is never high for two consecutive cycles and is only asserted in POP_HI.
- A frame is not aborted by fifo_empty. Frame byte j waits in IDLE until data arrives, and SYNC is not re-sent mid-frame.
- Reset in any state: the next cycle shows all reset values, and any in-flight byte is discarded.

## Timing
- Minimum 6 cycles per byte (IDLE, WAIT, LOAD, POP_HI, POP_LO, SETTLE) with SETTLE_CYCLES=1 and tx_ready held high.
- fifo_empty falls at cycle t (IDLE sees it) → WAIT at t+1 → LOAD captures at the end of t+2 → tx_valid=1 at t+3 → fifo_read_en=1 at t+3.
- With a sync byte: SYNC adds at least 1 cycle plus tx stall cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package fifo_drain_pkg: state enum (IDLE, SYNC, WAIT, LOAD, POP_HI, POP_LO, SETTLE), 3-bit encoding; default SYNC_BYTE constant.
- Sub-module byte_tx_slot: a one-entry output register that owns tx_data/tx_valid, with load and handshake-clear logic. The FSM, frame counter and settle counter live in the top level.

## Test plan
- Reset: hold reset 3 cycles while driving random inputs. All outputs are 0 during reset and on the cycle after release.
- Single byte (FRAME_LEN=0, tx_ready=1): write 8'h3C.
  - One fifo_read_en pulse, 1 cycle wide.
  - tx_data=3C with tx_valid for 1 cycle.
  - byte_count=1; busy drops 6 cycles after empty falls.
- Backpressure: write 11,22,33 with tx_ready=0 for 20 cycles.
  - tx_data stays at 11 and exactly one pop occurs.
  - Release tx_ready: output is 11,22,33 in order with 3 pops total, and the FIFO ends empty.
- Framing (FRAME_LEN=4): write 6 bytes 01..06. TX sequence is A5,01,02,03,04,A5,05,06.
- Enable drop: deassert enable in the cycle after LOAD. That byte is transmitted and the pop completes. No further pop while the FIFO still holds data. Re-enable to resume.
- Reset mid-pop: assert reset in POP_HI. fifo_read_en=0, tx_valid=0 and byte_count=0 on the next cycle, and state returns to IDLE.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO drain controller.
package fifo_drain_pkg;

  // Sequencer states. IDLE must stay at zero so a cleared state register reads as idle.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    WAIT   = 3'd2,
    LOAD   = 3'd3,
    POP_HI = 3'd4,
    POP_LO = 3'd5,
    SETTLE = 3'd6
  } state_e;

  // Frame header byte used when the instantiating level does not override it.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Counter widths.
  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned COUNT_W  = 16;
  localparam int unsigned FRAME_W  = 16;

endpackage

// File: rtl/fifo_drain_ctrl_byte_tx_slot.sv
// One-entry output register toward the byte-serial transmitter.
//
// Handshake: tx_valid/tx_data are registered. A byte transfers at a rising edge
// where tx_valid and tx_ready are both high; tx_valid then drops on that edge.
// tx_data never changes while tx_valid is high, because the controller only
// asserts load when the slot is empty.
module byte_tx_slot (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       valid_next
);

  logic [7:0] data_q;
  logic [7:0] data_d;
  logic       valid_q;
  logic       valid_d;

  // Load a new byte, or retire the held byte on a completed handshake.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (valid_q && tx_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot register; reset discards any in-flight byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data    = data_q;
  assign tx_valid   = valid_q;
  // Next-cycle valid, used by the parent to register busy without a combinational output path.
  assign valid_next = valid_d;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains the 8-bit sample FIFO into the byte-serial transmitter.
// Generates the FIFO's edge-sensitive read_en pulse (the FIFO advances on its
// falling edge), waits out the FIFO's output lag before sampling d_out, and
// optionally prefixes every FRAME_LEN data bytes with SYNC_BYTE.
// SETTLE_CYCLES must lie in 1..15.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int unsigned FRAME_LEN     = 0,
  parameter logic [7:0]  SYNC_BYTE     = DEFAULT_SYNC_BYTE,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                sys_clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                fifo_empty,
  input  logic [7:0]          fifo_dout,
  output logic                fifo_read_en,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic [COUNT_W-1:0]  byte_count,
  output state_e              state_dbg
);

  localparam bit                  FRAMING     = (FRAME_LEN != 0);
  localparam logic [FRAME_W-1:0]  FRAME_LAST  = FRAMING ? FRAME_W'(FRAME_LEN - 1) : '0;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [COUNT_W-1:0]   byte_count_q, byte_count_d;
  logic                 read_en_q, read_en_d;
  logic                 busy_q, busy_d;

  logic                 slot_load;
  logic [7:0]           slot_data;
  logic                 slot_valid_next;

  byte_tx_slot u_slot (
    .clk        (sys_clock),
    .reset      (reset),
    .load       (slot_load),
    .load_data  (slot_data),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .valid_next (slot_valid_next)
  );

  // Next-state, counters and slot load requests.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    settle_cnt_d = settle_cnt_q;
    byte_count_d = byte_count_q;
    slot_load    = 1'b0;
    slot_data    = fifo_dout;

    case (state_q)
      IDLE: begin
        // enable gates only the start of a new byte; a frame in progress simply
        // waits here for more data rather than being abandoned.
        if (enable && !fifo_empty) begin
          if (FRAMING && (frame_cnt_q == '0)) begin
            // The header goes out only through an empty slot, so the previous
            // frame's last byte is never overwritten.
            if (!tx_valid) begin
              state_d   = SYNC;
              slot_load = 1'b1;
              slot_data = SYNC_BYTE;
            end
          end else begin
            state_d = WAIT;
          end
        end
      end

      SYNC: begin
        if (tx_valid && tx_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        // Give the FIFO time to present the head byte on d_out.
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = '0;
          state_d      = LOAD;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      LOAD: begin
        // Capture only into an empty slot; otherwise stall under TX backpressure.
        if (!tx_valid) begin
          slot_load    = 1'b1;
          byte_count_d = byte_count_q + 1'b1;
          if (FRAMING) begin
            frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + 1'b1;
          end
          state_d = POP_HI;
        end
      end

      POP_HI:  state_d = POP_LO;
      POP_LO:  state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered outputs are derived from next-cycle values so they line up with the state.
    read_en_d = (state_d == POP_HI);
    busy_d    = (state_d != IDLE) || slot_valid_next;
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      settle_cnt_q <= '0;
      byte_count_q <= '0;
      read_en_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      byte_count_q <= byte_count_d;
      read_en_q    <= read_en_d;
      busy_q       <= busy_d;
    end
  end

  assign fifo_read_en = read_en_q;
  assign busy         = busy_q;
  assign byte_count   = byte_count_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: one instance without framing, one with FRAME_LEN=4.
// A behavioural FIFO pops its head when the selected instance's read_en falls.
module tb_fifo_drain_ctrl;
  import fifo_drain_pkg::*;

  // ---------------- clock / reset ----------------
  logic sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  logic       reset;
  logic       enable;
  logic       tx_ready;
  logic       sel;          // 0: FIFO talks to dut0, 1: to dut1
  logic       noise;        // forces garbage onto the FIFO outputs during reset
  logic [7:0] noise_byte;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout  = 8'h00;

  logic en0, en1, emp0, emp1;
  logic rd0, rd1, txv0, txv1, busy0, busy1;
  logic [7:0] txd0, txd1;
  logic [15:0] cnt0, cnt1;
  state_e st0, st1;

  assign en0  = sel ? 1'b0 : enable;
  assign en1  = sel ? enable : 1'b0;
  assign emp0 = sel ? 1'b1 : fifo_empty;
  assign emp1 = sel ? fifo_empty : 1'b1;

  fifo_drain_ctrl #(.FRAME_LEN(0), .SYNC_BYTE(8'hA5), .SETTLE_CYCLES(1)) dut0 (
    .sys_clock(sys_clock), .reset(reset), .enable(en0), .fifo_empty(emp0),
    .fifo_dout(fifo_dout), .fifo_read_en(rd0), .tx_data(txd0), .tx_valid(txv0),
    .tx_ready(tx_ready), .busy(busy0), .byte_count(cnt0), .state_dbg(st0));

  fifo_drain_ctrl #(.FRAME_LEN(4), .SYNC_BYTE(8'hA5), .SETTLE_CYCLES(1)) dut1 (
    .sys_clock(sys_clock), .reset(reset), .enable(en1), .fifo_empty(emp1),
    .fifo_dout(fifo_dout), .fifo_read_en(rd1), .tx_data(txd1), .tx_valid(txv1),
    .tx_ready(tx_ready), .busy(busy1), .byte_count(cnt1), .state_dbg(st1));

  // ---------------- FIFO model and TX monitor ----------------
  logic [7:0] fq[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int pulse0 = 0, pulse1 = 0, dbl0 = 0, dbl1 = 0;
  logic rd_prev0 = 1'b0, rd_prev1 = 1'b0;

  always @(negedge sys_clock) begin
    if (rd0 === 1'b1) pulse0++;
    if (rd1 === 1'b1) pulse1++;
    if (rd0 === 1'b1 && rd_prev0 === 1'b1) dbl0++;
    if (rd1 === 1'b1 && rd_prev1 === 1'b1) dbl1++;
    if ((sel ? rd_prev1 : rd_prev0) === 1'b1 && (sel ? rd1 : rd0) === 1'b0 && fq.size() > 0)
      void'(fq.pop_front());
    rd_prev0 = rd0;
    rd_prev1 = rd1;
    if ((sel ? txv1 : txv0) === 1'b1 && tx_ready === 1'b1)
      got_q.push_back(sel ? txd1 : txd0);
    fifo_empty = (fq.size() == 0) && !noise;
    fifo_dout  = (fq.size() != 0) ? fq[0] : noise_byte;
  end

  // ---------------- scoreboard helpers ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge sys_clock);
    #1;
  endtask

  task automatic drive_at_edge();
    @(posedge sys_clock);
    #2;
  endtask

  task automatic chk_quiet(input string tag, input logic rd, input logic v, input logic [7:0] d,
                           input logic b, input logic [15:0] c, input state_e s);
    chk({tag, "_rd"},    32'(rd), 32'd0);
    chk({tag, "_valid"}, 32'(v),  32'd0);
    chk({tag, "_data"},  32'(d),  32'd0);
    chk({tag, "_busy"},  32'(b),  32'd0);
    chk({tag, "_count"}, 32'(c),  32'd0);
    chk({tag, "_state"}, 32'(s),  32'(IDLE));
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        push;
    logic [7:0]  din;
    logic        rdy;
    logic        exp_rd;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_busy;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[8];
  int   base;
  logic done;

  initial begin
    // Single byte 3C, tx_ready high; row k is cycle k after the write.
    vecs[0] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 16'd1};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 16'd1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 16'd1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 16'd1};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 16'd1};

    reset = 1'b1; enable = 1'b0; tx_ready = 1'b0; sel = 1'b0;
    noise = 1'b0; noise_byte = 8'h00;

    // ---- reset with random inputs ----
    for (int i = 0; i < 3; i++) begin
      drive_at_edge();
      enable     = 1'($urandom_range(0, 1));
      tx_ready   = 1'($urandom_range(0, 1));
      noise      = 1'($urandom_range(0, 1));
      noise_byte = 8'($urandom_range(0, 255));
      step();
      chk_quiet($sformatf("rst%0d_d0", i), rd0, txv0, txd0, busy0, cnt0, st0);
      chk_quiet($sformatf("rst%0d_d1", i), rd1, txv1, txd1, busy1, cnt1, st1);
    end
    drive_at_edge();
    reset = 1'b0; enable = 1'b0; noise = 1'b0; tx_ready = 1'b1;
    step();
    chk_quiet("rel_d0", rd0, txv0, txd0, busy0, cnt0, st0);
    step();
    chk_quiet("post_rel_d0", rd0, txv0, txd0, busy0, cnt0, st0);
    chk_quiet("post_rel_d1", rd1, txv1, txd1, busy1, cnt1, st1);

    // ---- single byte, table driven ----
    drive_at_edge();
    enable = 1'b1;
    got_q.delete();
    base = pulse0;
    for (int k = 0; k < 8; k++) begin
      drive_at_edge();
      if (vecs[k].push) fq.push_back(vecs[k].din);
      tx_ready = vecs[k].rdy;
      step();
      chk($sformatf("single_c%0d_rd", k),    32'(rd0),   32'(vecs[k].exp_rd));
      chk($sformatf("single_c%0d_valid", k), 32'(txv0),  32'(vecs[k].exp_valid));
      chk($sformatf("single_c%0d_data", k),  32'(txd0),  32'(vecs[k].exp_data));
      chk($sformatf("single_c%0d_busy", k),  32'(busy0), 32'(vecs[k].exp_busy));
      chk($sformatf("single_c%0d_count", k), 32'(cnt0),  32'(vecs[k].exp_cnt));
    end
    chk("single_pulses", 32'(pulse0 - base), 32'd1);
    exp_q = '{8'h3C};
    check_stream("single_tx");

    // ---- backpressure ----
    drive_at_edge();
    got_q.delete();
    base = pulse0;
    tx_ready = 1'b0;
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    repeat (20) step();
    chk("bp_hold_data",  32'(txd0), 32'h11);
    chk("bp_hold_valid", 32'(txv0), 32'd1);
    chk("bp_one_pop",    32'(pulse0 - base), 32'd1);
    chk("bp_no_accept",  32'(got_q.size()), 32'd0);
    drive_at_edge();
    tx_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      done = (got_q.size() >= 3) && (st0 == IDLE) && (busy0 == 1'b0);
    end
    chk("bp_drain_done", 32'(done), 32'd1);
    exp_q = '{8'h11, 8'h22, 8'h33};
    check_stream("bp_tx");
    chk("bp_pops",       32'(pulse0 - base), 32'd3);
    chk("bp_fifo_empty", 32'(fq.size()), 32'd0);
    chk("bp_count",      32'(cnt0), 32'd4);

    // ---- framing on dut1 (FRAME_LEN=4) ----
    drive_at_edge();
    sel = 1'b1;
    got_q.delete();
    for (int b = 1; b <= 6; b++) fq.push_back(8'(b));
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      done = (got_q.size() >= 8) && (st1 == IDLE) && (busy1 == 1'b0) && (fq.size() == 0);
    end
    chk("frame_done", 32'(done), 32'd1);
    exp_q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h05, 8'h06};
    check_stream("frame_tx");
    chk("frame_count",  32'(cnt1), 32'd6);
    chk("frame_pulses", 32'(pulse1), 32'd6);

    // ---- enable drop right after LOAD ----
    drive_at_edge();
    sel = 1'b0;
    got_q.delete();
    base = pulse0;
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      done = (st0 == LOAD);
    end
    chk("en_reach_load", 32'(done), 32'd1);
    drive_at_edge();
    enable = 1'b0;
    step();
    chk("en_pop_hi", 32'(rd0), 32'd1);
    repeat (15) step();
    exp_q = '{8'hAA};
    check_stream("en_drop_tx");
    chk("en_drop_pops",  32'(pulse0 - base), 32'd1);
    chk("en_drop_fifo",  32'(fq.size()), 32'd1);
    chk("en_drop_state", 32'(st0), 32'(IDLE));
    chk("en_drop_busy",  32'(busy0), 32'd0);
    drive_at_edge();
    enable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      done = (got_q.size() >= 2) && (st0 == IDLE) && (busy0 == 1'b0);
    end
    chk("en_resume_done", 32'(done), 32'd1);
    exp_q = '{8'hAA, 8'hBB};
    check_stream("en_resume_tx");
    chk("en_resume_pops",  32'(pulse0 - base), 32'd2);
    chk("en_resume_fifo",  32'(fq.size()), 32'd0);
    chk("en_resume_count", 32'(cnt0), 32'd6);

    // ---- reset during POP_HI ----
    drive_at_edge();
    got_q.delete();
    fq.push_back(8'h5A);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      done = (rd0 == 1'b1);
    end
    chk("rstpop_reach", 32'(done), 32'd1);
    chk("rstpop_state_before", 32'(st0), 32'(POP_HI));
    reset = 1'b1;
    step();
    chk_quiet("rstpop", rd0, txv0, txd0, busy0, cnt0, st0);
    drive_at_edge();
    reset = 1'b0;
    step();
    chk("rstpop_after_state", 32'(st0), 32'(IDLE));
    chk("rstpop_after_rd",    32'(rd0), 32'd0);

    // ---- global read_en shape ----
    chk("no_double_rd0", 32'(dbl0), 32'd0);
    chk("no_double_rd1", 32'(dbl1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
